// File: rtl/channel_layout_ctrl.sv
// ============================================================================
// Module   : channel_layout_ctrl
// Brief    : Per-frame channel layout (count, iterative divide) plus row tracker
// Revision : 1.0
// ============================================================================
`default_nettype none

module channel_layout_ctrl #(
  parameter  int MAX_CHAN_COUNT = 10,
  parameter  int VER_RES        = 480,
  parameter  int OFFSET         = 0,
  localparam int ROW_W          = $clog2(VER_RES),
  localparam int CHAN_W         = $clog2(MAX_CHAN_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic                      frame_start,
  input  logic                      line_start,
  input  logic [ROW_W-1:0]          pixel_row,
  output logic                      layout_valid,
  output logic [CHAN_W-1:0]         channel_count,
  output logic [ROW_W-1:0]          channel_height,
  output logic                      is_channel,
  output logic [CHAN_W-1:0]         channel_number,
  output logic [ROW_W-1:0]          channel_offset,
  output logic [ROW_W-1:0]          row_in_channel
);

  localparam int STEP_W = $clog2(ROW_W + 1);

  localparam logic [ROW_W-1:0]  c_dividend  = ROW_W'(VER_RES - OFFSET);
  localparam logic [ROW_W-1:0]  c_offset    = ROW_W'(OFFSET);
  localparam logic [CHAN_W-1:0] c_last_bit  = CHAN_W'(MAX_CHAN_COUNT - 1);
  localparam logic [STEP_W-1:0] c_div_steps = STEP_W'(ROW_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_DIVIDE = 2'd2,
    S_READY  = 2'd3
  } state_t;

  state_t                    r_state;
  logic [MAX_CHAN_COUNT-1:0] r_shadow;
  logic [CHAN_W-1:0]         r_index_table [MAX_CHAN_COUNT];
  logic [CHAN_W-1:0]         r_scan_idx;
  logic [CHAN_W-1:0]         r_count;
  logic [STEP_W-1:0]         r_step;
  logic [ROW_W-1:0]          r_rem;
  logic [ROW_W-1:0]          r_dvd;
  logic [ROW_W-1:0]          r_quot;
  logic [CHAN_W-1:0]         r_vis;

  logic                      r_layout_valid;
  logic [CHAN_W-1:0]         r_channel_count;
  logic [ROW_W-1:0]          r_channel_height;
  logic                      r_is_channel;
  logic [CHAN_W-1:0]         r_channel_number;
  logic [ROW_W-1:0]          r_channel_offset;
  logic [ROW_W-1:0]          r_row_in_channel;

  // Restoring divider step: shift in the next dividend bit, subtract if it fits.
  logic [ROW_W:0]   w_rem_shift;
  logic [ROW_W:0]   w_divisor;
  logic             w_ge;
  logic [ROW_W-1:0] w_rem_next;

  assign w_rem_shift = {r_rem, r_dvd[ROW_W-1]};
  assign w_divisor   = {{(ROW_W + 1 - CHAN_W){1'b0}}, r_count};
  assign w_ge        = (w_rem_shift >= w_divisor);
  assign w_rem_next  = w_ge ? ROW_W'(w_rem_shift - w_divisor) : w_rem_shift[ROW_W-1:0];

  logic              w_row_at;
  logic              w_row_after;
  logic [ROW_W-1:0]  w_ric_inc;
  logic              w_wrap;
  logic [CHAN_W-1:0] w_vis_next;
  logic [ROW_W-1:0]  w_ric_next;
  logic [ROW_W-1:0]  w_off_next;
  logic              w_in_chan;

  assign w_row_at    = (pixel_row == c_offset);
  assign w_row_after = (pixel_row > c_offset);
  assign w_ric_inc   = r_row_in_channel + ROW_W'(1);
  assign w_wrap      = (w_ric_inc == r_channel_height);
  assign w_vis_next  = w_row_at ? '0 : (w_wrap ? r_vis + CHAN_W'(1) : r_vis);
  assign w_ric_next  = (w_row_at || w_wrap) ? '0 : w_ric_inc;
  assign w_off_next  = w_row_at ? c_offset
                     : (w_wrap ? r_channel_offset + r_channel_height : r_channel_offset);
  assign w_in_chan   = (w_row_at || w_row_after) && (r_channel_count != '0)
                     && (w_vis_next < r_channel_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_shadow         <= '0;
      for (int i = 0; i < MAX_CHAN_COUNT; i++) r_index_table[i] <= '0;
      r_scan_idx       <= '0;
      r_count          <= '0;
      r_step           <= '0;
      r_rem            <= '0;
      r_dvd            <= '0;
      r_quot           <= '0;
      r_vis            <= '0;
      r_layout_valid   <= 1'b0;
      r_channel_count  <= '0;
      r_channel_height <= '0;
      r_is_channel     <= 1'b0;
      r_channel_number <= '0;
      r_channel_offset <= '0;
      r_row_in_channel <= '0;
    end else if (frame_start) begin
      // Restart from any state; a coincident line_start is dropped.
      r_state          <= S_COUNT;
      r_shadow         <= channel_enable;
      r_scan_idx       <= '0;
      r_count          <= '0;
      r_layout_valid   <= 1'b0;
      r_vis            <= '0;
      r_is_channel     <= 1'b0;
      r_channel_number <= '0;
      r_channel_offset <= '0;
      r_row_in_channel <= '0;
    end else begin
      case (r_state)
        S_COUNT: begin
          if (r_shadow[r_scan_idx]) begin
            r_index_table[r_count] <= r_scan_idx;
            r_count                <= r_count + CHAN_W'(1);
          end
          if (r_scan_idx == c_last_bit) begin
            r_state <= S_DIVIDE;
            r_step  <= '0;
            r_rem   <= '0;
            r_dvd   <= c_dividend;
            r_quot  <= '0;
          end else begin
            r_scan_idx <= r_scan_idx + CHAN_W'(1);
          end
        end
        S_DIVIDE: begin
          // One extra cycle after the last quotient bit publishes the result.
          if (r_step == c_div_steps) begin
            r_channel_count  <= r_count;
            r_channel_height <= (r_count == '0) ? '0 : r_quot;
            r_layout_valid   <= 1'b1;
            r_state          <= S_READY;
          end else begin
            r_rem  <= w_rem_next;
            r_dvd  <= r_dvd << 1;
            r_quot <= {r_quot[ROW_W-2:0], w_ge};
            r_step <= r_step + STEP_W'(1);
          end
        end
        S_READY: begin
          if (line_start) begin
            if (w_row_at || w_row_after) begin
              r_vis            <= w_vis_next;
              r_row_in_channel <= w_ric_next;
              r_channel_offset <= w_off_next;
              r_is_channel     <= w_in_chan;
              r_channel_number <= w_in_chan ? r_index_table[w_vis_next] : '0;
            end else begin
              r_vis            <= '0;
              r_row_in_channel <= '0;
              r_channel_offset <= '0;
              r_is_channel     <= 1'b0;
              r_channel_number <= '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign layout_valid   = r_layout_valid;
  assign channel_count  = r_channel_count;
  assign channel_height = r_channel_height;
  assign is_channel     = r_is_channel;
  assign channel_number = r_channel_number;
  assign channel_offset = r_channel_offset;
  assign row_in_channel = r_row_in_channel;

endmodule

`default_nettype wire

// File: tb/tb_channel_layout_ctrl.sv
// ============================================================================
// Module   : tb_channel_layout_ctrl
// Brief    : Scoreboard bench for channel_layout_ctrl (OFFSET 0 and 40 instances)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_channel_layout_ctrl;

  localparam int VRES  = 480;
  localparam int OFF_B = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] channel_enable;
  logic       frame_start;
  logic       line_start;
  logic [8:0] pixel_row;

  logic       a_valid, b_valid;
  logic [3:0] a_count, b_count;
  logic [8:0] a_height, b_height;
  logic       a_is_ch, b_is_ch;
  logic [3:0] a_num, b_num;
  logic [8:0] a_off, b_off;
  logic [8:0] a_ric, b_ric;

  logic       sel;
  logic       m_valid;
  logic [3:0] m_count;
  logic [8:0] m_height;
  logic       m_is_ch;
  logic [3:0] m_num;
  logic [8:0] m_off;
  logic [8:0] m_ric;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         row;
    logic       is_ch;
    logic [3:0] num;
    logic [8:0] off;
    logic [8:0] ric;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  channel_layout_ctrl #(.MAX_CHAN_COUNT(10), .VER_RES(VRES), .OFFSET(0)) dut (
    .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable),
    .frame_start(frame_start), .line_start(line_start), .pixel_row(pixel_row),
    .layout_valid(a_valid), .channel_count(a_count), .channel_height(a_height),
    .is_channel(a_is_ch), .channel_number(a_num), .channel_offset(a_off),
    .row_in_channel(a_ric)
  );

  channel_layout_ctrl #(.MAX_CHAN_COUNT(10), .VER_RES(VRES), .OFFSET(OFF_B)) dut_off (
    .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable),
    .frame_start(frame_start), .line_start(line_start), .pixel_row(pixel_row),
    .layout_valid(b_valid), .channel_count(b_count), .channel_height(b_height),
    .is_channel(b_is_ch), .channel_number(b_num), .channel_offset(b_off),
    .row_in_channel(b_ric)
  );

  always_comb begin
    if (sel) begin
      m_valid = b_valid; m_count = b_count; m_height = b_height; m_is_ch = b_is_ch;
      m_num = b_num; m_off = b_off; m_ric = b_ric;
    end else begin
      m_valid = a_valid; m_count = a_count; m_height = a_height; m_is_ch = a_is_ch;
      m_num = a_num; m_off = a_off; m_ric = a_ric;
    end
  end

  // Reference: row -> (channel ordinal, row within it) by plain division.
  function automatic exp_t model_row(input int row, input logic [9:0] en, input int off);
    exp_t e;
    int   cnt, h, d, v, seen;
    e = '{row: row, is_ch: 1'b0, num: 4'd0, off: 9'd0, ric: 9'd0};
    cnt = 0;
    for (int k = 0; k < 10; k++) if (en[k]) cnt++;
    if (cnt != 0 && row >= off) begin
      h = (VRES - off) / cnt;
      d = row - off;
      v = d / h;
      if (v < cnt) begin
        e.is_ch = 1'b1;
        e.ric   = 9'(d % h);
        e.off   = 9'(off + v * h);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
          if (en[k]) begin
            if (seen == v) e.num = 4'(k);
            seen++;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic run_rows(input int first, input int last, input logic [9:0] en, input int off);
    exp_t e;
    for (int r = first; r <= last; r++) begin
      @(negedge clk);
      line_start = 1'b1;
      pixel_row  = 9'(r);
      sb.push_back(model_row(r, en, off));
      @(negedge clk);
      line_start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (m_is_ch !== e.is_ch || m_num !== e.num ||
          (e.is_ch && (m_off !== e.off || m_ric !== e.ric))) begin
        errors++;
        $display("FAIL row_%0d: got is_ch=%b ch=%0d off=%0d ric=%0d, want is_ch=%b ch=%0d off=%0d ric=%0d",
                 e.row, m_is_ch, m_num, m_off, m_ric, e.is_ch, e.num, e.off, e.ric);
      end
    end
  endtask

  task automatic start_frame(input logic [9:0] en, input int exp_cnt, input int exp_h);
    int n;
    @(negedge clk);
    channel_enable = en;
    frame_start    = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: got %b, want 0", m_valid);
    end
    n = 0;
    while (m_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL layout_latency: got %0d cycles, want 20", n);
    end
    checks++;
    if (m_count !== 4'(exp_cnt) || m_height !== 9'(exp_h)) begin
      errors++;
      $display("FAIL layout_values: got count=%0d height=%0d, want count=%0d height=%0d",
               m_count, m_height, exp_cnt, exp_h);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; channel_enable = '0; frame_start = 1'b0; line_start = 1'b0; pixel_row = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_valid, a_count, a_height, a_is_ch, a_num, a_off, a_ric,
         b_valid, b_count, b_height, b_is_ch, b_num, b_off, b_ric} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b count=%0d height=%0d, want all 0", a_valid, a_count, a_height);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %b/%b, want 0/0", a_valid, b_valid);
    end
  endtask

  task automatic test_three_channels();
    sel = 1'b0;
    start_frame(10'b0000100101, 3, 160);
    run_rows(0, VRES - 1, 10'b0000100101, 0);
  endtask

  task automatic test_seven_remainder();
    sel = 1'b0;
    start_frame(10'b0001111111, 7, 68);
    run_rows(0, VRES - 1, 10'b0001111111, 0);
  endtask

  task automatic test_offset();
    sel = 1'b1;
    start_frame(10'b1111000000, 4, 110);
    run_rows(0, VRES - 1, 10'b1111000000, OFF_B);
    sel = 1'b0;
  endtask

  task automatic test_no_channels();
    sel = 1'b0;
    start_frame(10'b0000000000, 0, 0);
    run_rows(0, VRES - 1, 10'b0000000000, 0);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_valid: got %b, want 1", m_valid);
    end
  endtask

  task automatic test_enable_midframe();
    sel = 1'b0;
    start_frame(10'b0000000001, 1, 480);
    run_rows(0, 199, 10'b0000000001, 0);
    channel_enable = 10'b0000000011;
    run_rows(200, VRES - 1, 10'b0000000001, 0);
    start_frame(10'b0000000011, 2, 240);
    run_rows(0, VRES - 1, 10'b0000000011, 0);
  endtask

  task automatic test_restart();
    sel = 1'b0;
    @(negedge clk);
    channel_enable = 10'b0000000001;
    frame_start    = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (14) @(negedge clk);
    start_frame(10'b0001111111, 7, 68);
    run_rows(0, 10, 10'b0001111111, 0);
  endtask

  task automatic test_back_to_back();
    int n;
    sel = 1'b0;
    start_frame(10'b0000100101, 3, 160);
    run_rows(0, 5, 10'b0000100101, 0);
    @(negedge clk);
    frame_start = 1'b1; line_start = 1'b1; pixel_row = 9'd6;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0;
    checks++;
    if (m_is_ch !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL fs_wins: got is_ch=%b valid=%b, want 0/0", m_is_ch, m_valid);
    end
    n = 0;
    while (m_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles, want 20", n);
    end
    run_rows(0, 170, 10'b0000100101, 0);
  endtask

  task automatic test_reset_midop();
    int n;
    sel = 1'b0;
    start_frame(10'b0000100101, 3, 160);
    run_rows(0, 200, 10'b0000100101, 0);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_valid, a_count, a_height, a_is_ch, a_num, a_off, a_ric} !== '0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d height=%0d, want 0/0", a_count, a_height);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      line_start = 1'b1; pixel_row = 9'(r);
      @(negedge clk);
      line_start = 1'b0;
      checks++;
      if (a_is_ch !== 1'b0 || a_valid !== 1'b0) begin
        errors++;
        $display("FAIL not_ready_row_%0d: got is_ch=%b valid=%b, want 0/0", r, a_is_ch, a_valid);
      end
    end
    start_frame(10'b0000100101, 3, 160);
    run_rows(0, 10, 10'b0000100101, 0);
  endtask

  initial begin
    test_reset();
    test_three_channels();
    test_seven_remainder();
    test_offset();
    test_no_channels();
    test_enable_midframe();
    test_restart();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
